// File: rtl/packed_param_streamer_if.sv
// Handshake bundle between packed_param_streamer and its consumer.
// The checksum signal exists only when PACKED_STREAMER_CHECKSUM_EN is defined.
interface packed_param_streamer_if #(
    parameter int W  = 4,
    parameter int RW = 1,
    parameter int CW = 2
);
    logic          start;
    logic          abort;
    logic          out_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [RW-1:0] out_row;
    logic [CW-1:0] out_col;
    logic          out_last;
    logic          busy;
    logic          done;
`ifdef PACKED_STREAMER_CHECKSUM_EN
    logic [W-1:0]  checksum;
`endif

    modport master (
        input  start, abort, out_ready,
        output out_valid, out_data, out_row, out_col, out_last, busy, done
`ifdef PACKED_STREAMER_CHECKSUM_EN
        , output checksum
`endif
    );

    modport slave (
        output start, abort, out_ready,
        input  out_valid, out_data, out_row, out_col, out_last, busy, done
`ifdef PACKED_STREAMER_CHECKSUM_EN
        , input checksum
`endif
    );
endinterface

// File: rtl/packed_param_streamer.sv
// Walks a packed parameter table row-major, one element per valid/ready transfer.
// Define PACKED_STREAMER_CHECKSUM_EN to add a running XOR of the transferred elements.
module packed_param_streamer #(
    parameter int W    = 4,
    parameter int ROWS = 2,
    parameter int COLS = 3,
    parameter logic [ROWS-1:0][COLS-1:0][W-1:0] TABLE = {ROWS{W'(6), W'(14), W'(5)}}
) (
    input logic                    clk,
    input logic                    rst,
    packed_param_streamer_if.master bus
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic [RW-1:0] r_row;
    logic [RW-1:0] w_nextRow;
    logic [CW-1:0] r_col;
    logic [CW-1:0] w_nextCol;
    logic [W-1:0]  r_data;
    logic          r_last;
    logic          w_xfer;
    logic          w_atLast;
    logic          w_valid;
    logic          w_done;

    assign w_xfer   = (r_state == STREAM) && bus.out_ready;
    assign w_atLast = (r_row == RW'(ROWS - 1)) && (r_col == CW'(COLS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Abort wins over a same-cycle transfer, so the last element plus abort never reaches DONE.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:    if (bus.start) w_nextState = STREAM;
            STREAM: begin
                if (bus.abort) begin
                    w_nextState = IDLE;
                end else if (w_xfer && w_atLast) begin
                    w_nextState = DONE;
                end
            end
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_valid = 1'b0;
        w_done  = 1'b0;
        unique case (r_state)
            STREAM:  w_valid = 1'b1;
            DONE:    w_done  = 1'b1;
            default: ;
        endcase
    end

    // Indices rest at zero outside STREAM, so entering a walk needs no extra load.
    always_comb begin
        w_nextRow = r_row;
        w_nextCol = r_col;
        if (w_nextState != STREAM) begin
            w_nextRow = '0;
            w_nextCol = '0;
        end else if (w_xfer) begin
            if (r_col == CW'(COLS - 1)) begin
                w_nextCol = '0;
                w_nextRow = r_row + RW'(1);
            end else begin
                w_nextCol = r_col + CW'(1);
            end
        end
    end

    // Table lookup uses the next indices so data, indices and last all change on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row  <= '0;
            r_col  <= '0;
            r_data <= TABLE[0][0];
            r_last <= 1'b0;
        end else begin
            r_row  <= w_nextRow;
            r_col  <= w_nextCol;
            r_data <= TABLE[w_nextRow][w_nextCol];
            r_last <= (w_nextState == STREAM) &&
                      (w_nextRow == RW'(ROWS - 1)) && (w_nextCol == CW'(COLS - 1));
        end
    end

`ifdef PACKED_STREAMER_CHECKSUM_EN
    logic [W-1:0] r_checksum;

    // Holds its value after abort or done until the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_checksum <= '0;
        end else if ((r_state == IDLE) && bus.start) begin
            r_checksum <= '0;
        end else if (w_xfer) begin
            r_checksum <= r_checksum ^ r_data;
        end
    end

    assign bus.checksum = r_checksum;
`endif

    assign bus.out_valid = w_valid;
    assign bus.busy      = w_valid;
    assign bus.done      = w_done;
    assign bus.out_data  = r_data;
    assign bus.out_row   = r_row;
    assign bus.out_col   = r_col;
    assign bus.out_last  = r_last;
endmodule

// File: tb/tb_packed_param_streamer.sv
// Cycle-by-cycle vector table for the default 2x3 table, plus a 1x1 instance sequence.
// Checksum comparisons are active when PACKED_STREAMER_CHECKSUM_EN is defined.
module tb_packed_param_streamer;
    logic clk;
    logic rst;
    int   compareCount;
    int   mismatchCount;

    packed_param_streamer_if #(.W(4), .RW(1), .CW(2)) mainIf ();
    packed_param_streamer_if #(.W(4), .RW(1), .CW(1)) oneIf ();

    packed_param_streamer #(
        .W(4), .ROWS(2), .COLS(3)
    ) dutMain (
        .clk (clk),
        .rst (rst),
        .bus (mainIf)
    );

    packed_param_streamer #(
        .W(4), .ROWS(1), .COLS(1), .TABLE(4'hA)
    ) dutOne (
        .clk (clk),
        .rst (rst),
        .bus (oneIf)
    );

    typedef struct {
        int rdy;
        int st;
        int ab;
        int rs;
        int v;
        int b;
        int d;
        int l;
        int row;
        int col;
        int data;
        int cs;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    function automatic vec_t mk(input int rdy, input int st, input int ab, input int rs,
                                input int v, input int b, input int d, input int l,
                                input int row, input int col, input int data, input int cs);
        vec_t r;
        r.rdy = rdy; r.st = st; r.ab = ab; r.rs = rs;
        r.v = v; r.b = b; r.d = d; r.l = l;
        r.row = row; r.col = col; r.data = data; r.cs = cs;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        mainIf.out_ready = v.rdy[0];
        mainIf.start     = v.st[0];
        mainIf.abort     = v.ab[0];
        rst              = v.rs[0];
    endtask

    function automatic logic [31:0] mainActual();
        return 32'({mainIf.out_valid, mainIf.busy, mainIf.done, mainIf.out_last,
                    mainIf.out_row, mainIf.out_col, mainIf.out_data});
    endfunction

    function automatic logic [31:0] mainExpected(input vec_t v);
        return 32'({1'(v.v), 1'(v.b), 1'(v.d), 1'(v.l), 1'(v.row), 2'(v.col), 4'(v.data)});
    endfunction

    initial begin
        int waitCycles;

        clk = 1'b0;
        rst = 1'b1;
        compareCount  = 0;
        mismatchCount = 0;
        mainIf.start = 1'b0; mainIf.abort = 1'b0; mainIf.out_ready = 1'b0;
        oneIf.start  = 1'b0; oneIf.abort  = 1'b0; oneIf.out_ready  = 1'b1;

        // rdy st ab rs | valid busy done last row col data checksum
        vecs.push_back(mk(1,1,0,0, 0,0,0,0, 0,0,'h5,'h0));
        vecs.push_back(mk(1,0,0,0, 1,1,0,0, 0,0,'h5,'h0));
        vecs.push_back(mk(1,0,0,0, 1,1,0,0, 0,1,'hE,'h5));
        vecs.push_back(mk(1,0,0,0, 1,1,0,0, 0,2,'h6,'hB));
        vecs.push_back(mk(1,0,0,0, 1,1,0,0, 1,0,'h5,'hD));
        vecs.push_back(mk(1,0,0,0, 1,1,0,0, 1,1,'hE,'h8));
        vecs.push_back(mk(1,0,0,0, 1,1,0,1, 1,2,'h6,'h6));
        vecs.push_back(mk(1,1,0,0, 0,0,1,0, 0,0,'h5,'h0));
        vecs.push_back(mk(1,1,0,0, 0,0,0,0, 0,0,'h5,'h0));
        // second walk: backpressure at (0,1), stray start at (1,0)
        vecs.push_back(mk(1,0,0,0, 1,1,0,0, 0,0,'h5,'h0));
        vecs.push_back(mk(0,0,0,0, 1,1,0,0, 0,1,'hE,'h5));
        vecs.push_back(mk(0,0,0,0, 1,1,0,0, 0,1,'hE,'h5));
        vecs.push_back(mk(0,0,0,0, 1,1,0,0, 0,1,'hE,'h5));
        vecs.push_back(mk(1,0,0,0, 1,1,0,0, 0,1,'hE,'h5));
        vecs.push_back(mk(1,0,0,0, 1,1,0,0, 0,2,'h6,'hB));
        vecs.push_back(mk(1,1,0,0, 1,1,0,0, 1,0,'h5,'hD));
        vecs.push_back(mk(1,0,0,0, 1,1,0,0, 1,1,'hE,'h8));
        vecs.push_back(mk(1,0,0,0, 1,1,0,1, 1,2,'h6,'h6));
        vecs.push_back(mk(0,0,0,0, 0,0,1,0, 0,0,'h5,'h0));
        vecs.push_back(mk(1,1,0,0, 0,0,0,0, 0,0,'h5,'h0));
        // third walk: abort with a transfer at (0,2), then abort in IDLE and a replay
        vecs.push_back(mk(1,0,0,0, 1,1,0,0, 0,0,'h5,'h0));
        vecs.push_back(mk(1,0,0,0, 1,1,0,0, 0,1,'hE,'h5));
        vecs.push_back(mk(1,0,1,0, 1,1,0,0, 0,2,'h6,'hB));
        vecs.push_back(mk(1,0,1,0, 0,0,0,0, 0,0,'h5,'hD));
        vecs.push_back(mk(1,1,0,0, 0,0,0,0, 0,0,'h5,'hD));
        vecs.push_back(mk(1,0,0,0, 1,1,0,0, 0,0,'h5,'h0));
        vecs.push_back(mk(1,0,0,0, 1,1,0,0, 0,1,'hE,'h5));
        vecs.push_back(mk(1,0,0,0, 1,1,0,0, 0,2,'h6,'hB));
        vecs.push_back(mk(1,0,0,0, 1,1,0,0, 1,0,'h5,'hD));
        vecs.push_back(mk(1,0,0,1, 1,1,0,0, 1,1,'hE,'h8));
        // after reset at (1,1): fresh walk, abort in DONE must not suppress the pulse
        vecs.push_back(mk(1,1,0,0, 0,0,0,0, 0,0,'h5,'h0));
        vecs.push_back(mk(1,0,0,0, 1,1,0,0, 0,0,'h5,'h0));
        vecs.push_back(mk(1,0,0,0, 1,1,0,0, 0,1,'hE,'h5));
        vecs.push_back(mk(1,0,0,0, 1,1,0,0, 0,2,'h6,'hB));
        vecs.push_back(mk(1,0,0,0, 1,1,0,0, 1,0,'h5,'hD));
        vecs.push_back(mk(1,0,0,0, 1,1,0,0, 1,1,'hE,'h8));
        vecs.push_back(mk(1,0,0,0, 1,1,0,1, 1,2,'h6,'h6));
        vecs.push_back(mk(1,0,1,0, 0,0,1,0, 0,0,'h5,'h0));
        vecs.push_back(mk(1,0,0,0, 0,0,0,0, 0,0,'h5,'h0));

        @(negedge clk);
        checkOutput("reset_state", mainActual(), 32'(11'b0000_0_00_0101));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i), mainActual(), mainExpected(vecs[i]));
`ifdef PACKED_STREAMER_CHECKSUM_EN
            checkOutput($sformatf("vec%0d_checksum", i), 32'(mainIf.checksum), 32'(4'(vecs[i].cs)));
`endif
            applyStimulus(vecs[i]);
        end

        mainIf.start = 1'b0;
        mainIf.abort = 1'b0;

        // 1x1 table: the only element is also the last one
        @(negedge clk);
        checkOutput("one_idle", 32'({oneIf.out_valid, oneIf.done, oneIf.out_last, oneIf.out_data}),
                    32'({1'b0, 1'b0, 1'b0, 4'hA}));
        oneIf.start = 1'b1;
        @(negedge clk);
        oneIf.start = 1'b0;
        checkOutput("one_element", 32'({oneIf.out_valid, oneIf.busy, oneIf.done, oneIf.out_last,
                                        oneIf.out_row, oneIf.out_col, oneIf.out_data}),
                    32'({1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'hA}));
        waitCycles = 0;
        do begin
            @(negedge clk);
            waitCycles++;
        end while (!oneIf.done && waitCycles < 5);
        checkOutput("one_done_latency", 32'(waitCycles), 32'd1);
        checkOutput("one_done_valid", 32'(oneIf.out_valid), 32'd0);
`ifdef PACKED_STREAMER_CHECKSUM_EN
        checkOutput("one_checksum", 32'(oneIf.checksum), 32'hA);
`endif
        @(negedge clk);
        checkOutput("one_after_done", 32'({oneIf.out_valid, oneIf.done}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end
endmodule
